csa_cpa_resolver: RTL



---
 rtl/csa_cpa_resolver_pkg.sv | 23 ++
 rtl/csa_cpa_resolver_chunk.sv | 21 ++
 rtl/csa_cpa_resolver.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/csa_cpa_resolver_pkg.sv
// Shared definitions for the chunked carry-propagate resolver.
// Holds the FSM state encoding and the chunk-count / padded-width derivations.
package csa_cpa_resolver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  function automatic int unsigned padded_width(input int unsigned width, input int unsigned chunk);
    return num_chunks(width, chunk) * chunk;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_cpa_resolver_chunk.sv
// Combinational CHUNK-bit adder with carry-in/carry-out; one slice of the
// multi-cycle carry-propagate resolve.
module csa_cpa_chunk #(
  parameter int unsigned CHUNK = 6
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + (CHUNK + 1)'(ci);
    s     = total[CHUNK-1:0];
    co    = total[CHUNK];
  end

endmodule

// File: rtl/csa_cpa_resolver.sv
// Resolves a carry-save pair into binary, CHUNK bits per cycle with a
// registered inter-chunk carry; valid/ready on both sides.
module csa_cpa_resolver
  import csa_cpa_resolver_pkg::*;
#(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned CHUNK = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic             busy
);

  localparam int unsigned NC = num_chunks(WIDTH, CHUNK);
  localparam int unsigned PW = padded_width(WIDTH, CHUNK);
  localparam int unsigned IW = idx_width(NC);

  state_e          state_q, state_d;
  logic [PW-1:0]   op_sum_q, op_sum_d;
  logic [PW-1:0]   op_carry_q, op_carry_d;
  logic [PW-1:0]   res_q, res_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [WIDTH:0]  out_data_q, out_data_d;
  logic            busy_q, busy_d;

  logic [31:0]     base;
  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic            chunk_co;
  logic [PW-1:0]   res_w;
  logic [PW:0]     full;

  always_comb begin
    base    = 32'(idx_q) * CHUNK;
    chunk_a = op_sum_q[base +: CHUNK];
    chunk_b = op_carry_q[base +: CHUNK];
  end

  csa_cpa_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (chunk_a),
    .b  (chunk_b),
    .ci (carry_q),
    .s  (chunk_s),
    .co (chunk_co)
  );

  always_comb begin
    state_d     = state_q;
    op_sum_d    = op_sum_q;
    op_carry_d  = op_carry_q;
    res_d       = res_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;

    res_w = res_q;
    res_w[base +: CHUNK] = chunk_s;
    // Bit WIDTH is the top carry-out when unpadded, else a padded result bit.
    full = {chunk_co, res_w};

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          op_sum_d   = PW'(in_sum);
          op_carry_d = PW'(in_carry);
          res_d      = '0;
          carry_d    = 1'b0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        res_d   = res_w;
        carry_d = chunk_co;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(NC - 1)) begin
          idx_d       = '0;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = full[WIDTH:0];
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
        idx_d       = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_sum_q    <= '0;
      op_carry_q  <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_sum_q    <= op_sum_d;
      op_carry_q  <= op_carry_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule
